// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC parallel bus controller: FSM state
// encoding, default phase timing and the idle levels of the bus pins.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_SET = 3'd1,
    ST_A_STB = 3'd2,
    ST_A_HLD = 3'd3,
    ST_D_SET = 3'd4,
    ST_D_STB = 3'd5,
    ST_D_HLD = 3'd6,
    ST_FIN   = 3'd7
  } state_t;

  localparam int unsigned SETUP_CYC_DEF  = 2;
  localparam int unsigned STROBE_CYC_DEF = 4;
  localparam int unsigned HOLD_CYC_DEF   = 2;

  localparam logic       CS_N_IDLE   = 1'b1;
  localparam logic       A_D_IDLE    = 1'b1;
  localparam logic       WR_N_IDLE   = 1'b1;
  localparam logic       RD_N_IDLE   = 1'b1;
  localparam logic       AD_OE_IDLE  = 1'b0;
  localparam logic [7:0] AD_OUT_IDLE = 8'h00;

endpackage

// File: rtl/rtc_phase_cnt.sv
// 8-bit loadable down-counter timing every bus phase. It stops at zero so
// it rests at zero while the controller is idle.
module rtc_phase_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequences one-byte reads and writes onto the multiplexed address/data
// bus of the RTC chip. Every bus pin is registered from the current state,
// so pins lag the state register by one clock.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
  parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       a_d,
  output logic       wr_n,
  output logic       rd_n
);

  state_t     state;
  logic       rw_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       cnt_load;
  logic [7:0] cnt_val;
  logic       cnt_zero;
  logic       in_a;
  logic       in_d;

  // Counter preload for a phase: the phase length minus one, since the
  // state advances on the cycle the counter reads zero.
  function automatic logic [7:0] phase_len_m1(input state_t s);
    case (s)
      ST_A_SET, ST_D_SET: phase_len_m1 = 8'(SETUP_CYC - 1);
      ST_A_STB, ST_D_STB: phase_len_m1 = 8'(STROBE_CYC - 1);
      ST_A_HLD, ST_D_HLD: phase_len_m1 = 8'(HOLD_CYC - 1);
      default:            phase_len_m1 = 8'd0;
    endcase
  endfunction

  // Fixed phase order of a transaction.
  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_IDLE:  next_phase = ST_A_SET;
      ST_A_SET: next_phase = ST_A_STB;
      ST_A_STB: next_phase = ST_A_HLD;
      ST_A_HLD: next_phase = ST_D_SET;
      ST_D_SET: next_phase = ST_D_STB;
      ST_D_STB: next_phase = ST_D_HLD;
      ST_D_HLD: next_phase = ST_FIN;
      default:  next_phase = ST_IDLE;
    endcase
  endfunction

  // Reload the counter whenever the state is about to change.
  always_comb begin
    cnt_load = (state == ST_IDLE) ? req : cnt_zero;
    cnt_val  = phase_len_m1(next_phase(state));
    in_a     = (state == ST_A_SET) || (state == ST_A_STB) || (state == ST_A_HLD);
    in_d     = (state == ST_D_SET) || (state == ST_D_STB) || (state == ST_D_HLD);
  end

  rtc_phase_cnt u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Transaction FSM with its registered bus pins and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      cs_n    <= CS_N_IDLE;
      a_d     <= A_D_IDLE;
      wr_n    <= WR_N_IDLE;
      rd_n    <= RD_N_IDLE;
      ad_oe   <= AD_OE_IDLE;
      ad_out  <= AD_OUT_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
            state   <= ST_A_SET;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: begin
          if (cnt_zero) state <= next_phase(state);
        end
      endcase

      cs_n   <= !(in_a || in_d);
      a_d    <= !in_a;
      ad_oe  <= in_a || (in_d && !rw_q);
      ad_out <= in_a ? addr_q : ((in_d && !rw_q) ? wdata_q : AD_OUT_IDLE);
      wr_n   <= !((state == ST_A_STB) || ((state == ST_D_STB) && !rw_q));
      rd_n   <= !((state == ST_D_STB) && rw_q);
      busy   <= (state != ST_IDLE);
      done   <= (state == ST_FIN);

      // rd_n still low while the state already sits in D_HLD marks the
      // edge that closes the read strobe; that is the sampling edge.
      if ((state == ST_D_HLD) && !rd_n) rdata <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl with randomized transactions and a
// cycle-indexed reference model of the bus waveform.
module tb_rtc_bus_ctrl;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;
  localparam int P = S + T + H;
  localparam int L = 2 * P + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       a_d;
  logic       wr_n;
  logic       rd_n;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_rdata = 8'h00;

  typedef struct packed {
    logic       cs_n;
    logic       a_d;
    logic       wr_n;
    logic       rd_n;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
  } obs_t;

  rtc_bus_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .ad_in  (ad_in),
    .ad_out (ad_out),
    .ad_oe  (ad_oe),
    .cs_n   (cs_n),
    .a_d    (a_d),
    .wr_n   (wr_n),
    .rd_n   (rd_n)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.cs_n = cs_n; o.a_d = a_d; o.wr_n = wr_n; o.rd_n = rd_n;
    o.ad_oe = ad_oe; o.ad_out = ad_out; o.busy = busy; o.done = done;
    o.rdata = rdata;
    return o;
  endfunction

  function automatic obs_t idle_exp(input logic [7:0] rd);
    obs_t o;
    o.cs_n = 1'b1; o.a_d = 1'b1; o.wr_n = 1'b1; o.rd_n = 1'b1;
    o.ad_oe = 1'b0; o.ad_out = 8'h00; o.busy = 1'b0; o.done = 1'b0;
    o.rdata = rd;
    return o;
  endfunction

  // Expected pins k cycles after the accept edge: cycles 1..P are the
  // address phase, P+1..2P the data phase, each split setup/strobe/hold;
  // cycle 2P+1 carries done.
  function automatic obs_t txn_exp(input int k, input logic r,
                                   input logic [7:0] a, input logic [7:0] w,
                                   input logic [7:0] rd);
    obs_t o;
    bit   aph;
    bit   stb;
    int   j;
    o = idle_exp(rd);
    if (k == L) begin
      o.busy = 1'b1;
      o.done = 1'b1;
    end else if (k >= 1 && k < L) begin
      aph      = (k <= P);
      j        = aph ? k : k - P;
      stb      = (j > S) && (j <= S + T);
      o.busy   = 1'b1;
      o.cs_n   = 1'b0;
      o.a_d    = !aph;
      o.wr_n   = !(stb && (aph || !r));
      o.rd_n   = !(stb && !aph && r);
      o.ad_oe  = aph || !r;
      o.ad_out = aph ? a : (r ? 8'h00 : w);
    end
    return o;
  endfunction

  // One transaction with cycle-by-cycle comparison. hold keeps req high
  // afterwards, pulse_k raises req for the edge of that cycle, reset_k
  // pulls reset low for the edge of that cycle and ends the transaction.
  task automatic run_txn(input string name, input logic r, input logic [7:0] a,
                         input logic [7:0] w, input logic [7:0] v,
                         input bit hold, input int pulse_k, input int reset_k);
    obs_t       exp;
    obs_t       got;
    logic [7:0] rd_exp;
    @(negedge clk);
    req = 1'b1; rw = r; addr = a; wdata = w; ad_in = ~v;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    for (int k = 0; k <= L; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      got = observe();
      if (k == reset_k) begin
        model_rdata = 8'h00;
        exp = idle_exp(8'h00);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s_reset k=%0d got=%h exp=%h", name, k, got, exp);
        end
        reset = 1'b1;
        break;
      end
      rd_exp = (r && k >= P + S + T + 1) ? v : model_rdata;
      exp = txn_exp(k, r, a, w, rd_exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
      end
      ad_in = (k >= P + S + 1 && k <= P + S + T) ? v : ~v;
      if (k == pulse_k - 1) req = 1'b1;
      if (k == pulse_k) req = 1'b0;
      if (k == reset_k - 1) reset = 1'b0;
      if (k == L && r) model_rdata = v;
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    obs_t got;
    obs_t exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ad_in = 8'($urandom);
      got = observe();
      exp = idle_exp(model_rdata);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s idle=%0d got=%h exp=%h", name, i, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b1; rw = 1'b0; addr = 8'hA5; wdata = 8'h5A;
    ad_in = 8'hFF;
    model_rdata = 8'h00;
    idle_cycles("reset_hold", 3);
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    idle_cycles("reset_release", 3);
  endtask

  task automatic test_write();
    run_txn("write", 1'b0, 8'h21, 8'h45, 8'h00, 1'b0, -1, -1);
    idle_cycles("write_after", 2);
  endtask

  task automatic test_read();
    run_txn("read", 1'b1, 8'h22, 8'h00, 8'h59, 1'b0, -1, -1);
    idle_cycles("read_after", 2);
  endtask

  task automatic test_write_keeps_rdata();
    run_txn("write_keep_rdata", 1'b0, 8'h23, 8'($urandom), 8'hC3, 1'b0, -1, -1);
    idle_cycles("write_keep_after", 2);
  endtask

  task automatic test_ignored_req();
    run_txn("ignored_req", 1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, 5, -1);
    idle_cycles("ignored_req_after", 20);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 1'b1, -1, -1);
    run_txn("b2b_second", 1'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 1'b0, -1, -1);
    idle_cycles("b2b_after", 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_txn("random", 1'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 1'b0, -1, -1);
      idle_cycles("random_gap", 1 + int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    run_txn("reset_mid", 1'b0, 8'($urandom), 8'($urandom), 8'h00,
            1'b0, -1, 12);
    idle_cycles("reset_mid_after", 20);
  endtask

  initial begin
    req = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
    reset = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_write_keeps_rdata();
    test_ignored_req();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
